vga_timing_gen: RTL
===================

# vga_timing_gen

Pixel-timing source for the VGA display path. Generates the horizontal and vertical scan counters, active-low sync pulses, the active-video enable (`blank`), and per-frame status. It drives the `DrawX`/`DrawY`/`blank` inputs of every sprite/renderer block, such as the ROM+palette examples, which register color on the same `vga_clk`.

## Interface

Parameters:
- `H_VISIBLE`, default 640: visible pixels per line
- `H_FRONT`, default 16: horizontal front porch, in clocks
- `H_SYNC`, default 96: hsync width, in clocks
- `H_BACK`, default 48: horizontal back porch; line total = 800
- `V_VISIBLE`, default 480: visible lines
- `V_FRONT`, default 10: vertical front porch, in lines
- `V_SYNC`, default 2: vsync width, in lines
- `V_BACK`, default 33: vertical back porch; frame total = 525 lines

Ports:
- `vga_clk`  in  1: pixel clock. This is the only clock.
- `reset_n`  in  1: synchronous, active-low reset
- `pix_en`  in  1: pixel advance enable. When 0, all state holds.
- `hs`  out  1: hsync, active low
- `vs`  out  1: vsync, active low
- `blank`  out  1: 1 = active video (pixel may be drawn); 0 = blanking
- `sync`  out  1: composite sync, constant 0
- `DrawX`  out  10: horizontal counter, 0..799
- `DrawY`  out  10: vertical counter, 0..524
- `frame_start`  out  1: one-clock pulse when the counters enter (0,0)
- `frame_count`  out  16: number of frames started since reset

## Operation

- **Counters.**
  - `DrawX` and `DrawY` are the state registers themselves.
  - On each `vga_clk` edge with `reset_n`=1 and `pix_en`=1, `DrawX` increments.
  - At 799, `DrawX` wraps to 0 and `DrawY` increments.
  - At `DrawX`=799 and `DrawY`=524, both wrap to 0.
- **Decode.** All decoded outputs are registered from the next-state counter values, so they are aligned with `DrawX`/`DrawY` in the same cycle.
  - `hs`=0 iff 656 ≤ `DrawX` ≤ 751.
  - `vs`=0 iff 490 ≤ `DrawY` ≤ 491.
  - `blank`=1 iff `DrawX` < 640 and `DrawY` < 480.
  - Bounds come from the parameters: sync start = VISIBLE+FRONT; sync end = that value + SYNC − 1.
- **frame_start.**
  - Set to 1 on the edge where the counters advance into (0,0).
  - Cleared on the following edge, regardless of `pix_en`. It is never high for more than one clock.
- **frame_count.**
  - Increments on that same edge.
  - Wraps from 65535 to 0.
- **Reset.** While `reset_n`=0 at an edge:
  - `DrawX`←799, `DrawY`←524 (last pixel of the previous frame)
  - `hs`←1, `vs`←1, `blank`←0
  - `frame_start`←0, `frame_count`←0
  - These values match the decode at (799,524), so outputs are self-consistent.
  - Reset overrides `pix_en` and takes effect from any state, including mid-line and mid-sync.
- **After reset.** On the first edge with `reset_n`=1 and `pix_en`=1:
  - `DrawX`=0, `DrawY`=0, `blank`=1
  - `frame_start`=1, `frame_count`=1

## Timing

- Latency from counter state to `hs`/`vs`/`blank`: 0 cycles (same-cycle aligned). This holds without the macro.
- Line period is 800 enabled clocks; frame period is 420000 enabled clocks.
- `hs` low for 96 enabled clocks per line. `vs` low for 2 lines (1600 clocks), spanning full lines from `DrawX`=0.
- `pix_en`=0: counters, `hs`, `vs`, `blank` and `frame_count` hold; `frame_start` still self-clears.
- Reset asserted together with `pix_en`=1: reset wins.

## Configuration

- `VGA_PIPE_ALIGN_EN` defined:
  - `hs`, `vs`, `blank` and `frame_start` pass through one extra register stage.
  - They lag `DrawX`/`DrawY` by 1 enabled clock, which matches consumers that register color one cycle after sampling `DrawX`/`DrawY`.
  - Stage reset values are 1, 1, 0, 0.
  - The stage holds when `pix_en`=0. `frame_start` remains a single-clock pulse.
  - `DrawX`, `DrawY` and `frame_count` are not delayed.
- Not defined: the zero-skew behaviour described above applies, and no extra registers are present.

## Test plan

- **Reset and first frame.** Hold `reset_n`=0 for 3 clocks.
  - During reset: `DrawX`=799, `DrawY`=524, `hs`=`vs`=1, `blank`=0, `frame_count`=0.
  - First edge after release: `DrawX`=0, `DrawY`=0, `blank`=1, `frame_start`=1, `frame_count`=1.
  - Next edge: `frame_start`=0.
- **Line timing.** Free-run one line.
  - `hs`=0 exactly for `DrawX` 656..751.
  - `blank` falls at `DrawX`=640.
  - `DrawX` 799 → 0 with `DrawY`+1.
- **Frame timing.** Free-run two frames.
  - `vs`=0 exactly for `DrawY` 490..491.
  - `frame_start` pulses exactly 420000 clocks apart.
  - `frame_count` goes 1 → 2 → 3.
  - `blank`=0 for all `DrawY` ≥ 480.
- **Enable stall.**
  - Drop `pix_en` for 5 clocks immediately after (0,0) is entered: all outputs hold, `frame_start` is high for exactly 1 clock, `frame_count` increments once.
  - Drop `pix_en` at `DrawX`=700: `hs` stays 0 while stalled and resumes toward 751.
- **Mid-frame reset.** Pulse `reset_n`=0 for 1 clock at (300,200): the next outputs are the reset values, `frame_count`=0, and the following edge gives (0,0) with `frame_start`=1.
- **With `VGA_PIPE_ALIGN_EN`.**
  - `blank` is first 0 when `DrawX`=641.
  - `hs` is 0 for `DrawX` 657..752.
  - `frame_start`=1 when `DrawX`=1, `DrawY`=0.
  - After reset release, `blank` first rises when `DrawX`=1.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: scan position, sync and frame status bundle from the timing generator to renderers.
interface vga_timing_gen_if;
   logic        pix_en;
   logic        hs;
   logic        vs;
   logic        blank;
   logic        sync;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        frame_start;
   logic [15:0] frame_count;
   modport master (
      input  pix_en,
      output hs, vs, blank, sync, DrawX, DrawY, frame_start, frame_count
   );
   modport slave (
      output pix_en,
      input  hs, vs, blank, sync, DrawX, DrawY, frame_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA scan counters with sync/blank decode and frame status.
// Define VGA_PIPE_ALIGN_EN to delay hs/vs/blank/frame_start by one enabled clock.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input logic              vga_clk,
   input logic              reset_n,
   vga_timing_gen_if.master vga
);
   localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [9:0]  x, y, nx, ny;
   logic        hs_d, vs_d, blank_d, fs_d;
   logic        hs_n, vs_n, blank_n, wrap;
   logic [15:0] fc;

   // Decode from the next-state counters so registered outputs line up with DrawX/DrawY.
   always_comb begin
      wrap    = vga.pix_en && x == H_LAST && y == V_LAST;
      nx      = !vga.pix_en ? x : (x == H_LAST ? '0 : x + 10'd1);
      ny      = (!vga.pix_en || x != H_LAST) ? y : (y == V_LAST ? '0 : y + 10'd1);
      hs_n    = !(nx >= HS_FIRST && nx <= HS_LAST);
      vs_n    = !(ny >= VS_FIRST && ny <= VS_LAST);
      blank_n = nx < H_VIS && ny < V_VIS;
   end

   // Reset parks the scan on the last pixel so the first enabled edge opens a frame.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         x       <= H_LAST;
         y       <= V_LAST;
         hs_d    <= 1'b1;
         vs_d    <= 1'b1;
         blank_d <= 1'b0;
         fs_d    <= 1'b0;
         fc      <= '0;
      end else begin
         x       <= nx;
         y       <= ny;
         hs_d    <= hs_n;
         vs_d    <= vs_n;
         blank_d <= blank_n;
         fs_d    <= wrap;
         fc      <= fc + 16'(wrap);
      end
   end

`ifdef VGA_PIPE_ALIGN_EN
   logic hs_q, vs_q, blank_q, fs_q;

   // Leaving (0,0) happens exactly once per frame, which yields a one-clock delayed pulse even across stalls.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         fs_q <= vga.pix_en && x == '0 && y == '0;
         if (vga.pix_en) begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
         end
      end
   end

   assign vga.hs          = hs_q;
   assign vga.vs          = vs_q;
   assign vga.blank       = blank_q;
   assign vga.frame_start = fs_q;
`else
   assign vga.hs          = hs_d;
   assign vga.vs          = vs_d;
   assign vga.blank       = blank_d;
   assign vga.frame_start = fs_d;
`endif

   assign vga.sync        = 1'b0;
   assign vga.DrawX       = x;
   assign vga.DrawY       = y;
   assign vga.frame_count = fc;
endmodule
